// File: rtl/rv_decode_issue.sv
// Decode/issue stage: RV32 ADD/SUB/AND/OR/ADDI/ANDI/ORI into an
// ALU selector plus operands, with a local register file and writeback.
module rv_decode_issue #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        instruction_bits,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [4:0]        rd,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  output logic [CNT_W-1:0]  issued_cnt
);

  logic              valid_q, valid_d;
  logic [3:0]        bits_q, bits_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [4:0]        rd_q, rd_d;
  logic              ill_q, ill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rf_q [32];

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [4:0]        rs1, rs2;
  logic              is_r, is_i, f3_ok, legal;
  logic              accept;
  logic [DATA_W-1:0] op1, op2, imm;
  logic [3:0]        bits_n;
  logic [DATA_W-1:0] b_n;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign f3_ok  = (f3 == 3'b000) || (f3 == 3'b110)
               || (f3 == 3'b111);
  assign legal  = (is_r && (((f7 == 7'b0000000) && f3_ok)
               || ((f7 == 7'b0100000) && (f3 == 3'b000))))
               || (is_i && f3_ok);

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A same-cycle writeback wins over the stale register value.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (rs1 != 5'd0)
      op1 = (wb_en && (wb_rd == rs1)) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0)
      op2 = (wb_en && (wb_rd == rs2)) ? wb_data : rf_q[rs2];
  end

  assign imm = DATA_W'($signed(in_instr[31:20]));

  always_comb begin
    bits_n = '0;
    b_n    = '0;
    unique case (1'b1)
      is_r: begin
        bits_n = {in_instr[30], f3};
        b_n    = op2;
      end
      is_i: begin
        bits_n = {1'b0, f3};
        b_n    = imm;
      end
      default: begin
        bits_n = '0;
        b_n    = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    bits_d  = bits_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (out_ready)
      valid_d = 1'b0;
    if (accept && legal) begin
      valid_d = 1'b1;
      bits_d  = bits_n;
      a_d     = op1;
      b_d     = b_n;
      rd_d    = in_instr[11:7];
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (accept && !legal)
      ill_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bits_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bits_q  <= bits_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign out_valid        = valid_q;
  assign instruction_bits = bits_q;
  assign a                = a_q;
  assign b                = b_q;
  assign rd               = rd_q;
  assign illegal          = ill_q;
  assign issued_cnt       = cnt_q;

endmodule
